// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the fetch/data memory arbiter.
// Handshake: if_req/d_req are level requests sampled only while the arbiter is idle;
// once taken, address/we/wdata are latched and later changes are ignored. Each
// transaction ends with exactly one single-cycle if_ack or d_ack pulse (d_err qualifies
// d_ack). mem_en is a one-cycle strobe per access; mem_rdata is valid MEM_LAT cycles
// after it. busy is high from the cycle after the grant up to and including the ack.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic              d_err;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  // Requesters plus the memory: drive requests and read data, observe the rest.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_err, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_err, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port word memory between instruction fetch and
// the data load/store path. Each access runs IDLE -> ISSUE -> WAIT x MEM_LAT -> DONE;
// a misaligned data access skips straight to DONE with d_err.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: on simultaneous requests grant the requester
// that was not granted last; without it data always beats fetch.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic       win_data;
  logic       grant_data;

  // Fetch addresses are word aligned by construction; the low bits carry no meaning.
  logic unused_fetch_lsbs;
  assign unused_fetch_lsbs = ^bus.if_addr[1:0];

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_data;

  // Remember which requester won the most recent grant (reset: fetch, so data wins first tie).
  always_ff @(posedge clk) begin
    if (rst) begin
      last_data <= 1'b0;
    end else if (state == S_IDLE && (bus.if_req || bus.d_req)) begin
      last_data <= grant_data;
    end
  end

  // On a tie, grant whichever requester did not win last time.
  always_comb begin
    grant_data = bus.d_req;
    if (bus.d_req && bus.if_req) begin
      grant_data = !last_data;
    end
  end
`else
  assign grant_data = bus.d_req;
`endif

  assign bus.busy  = (state != S_IDLE);
  assign dbg_state = state;

  // Transaction sequencer; all requester and memory outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= 3'd0;
      win_data      <= 1'b0;
      bus.if_ack    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_ack     <= 1'b0;
      bus.d_err     <= 1'b0;
      bus.d_rdata   <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.if_ack <= 1'b0;
      bus.d_ack  <= 1'b0;
      bus.d_err  <= 1'b0;
      bus.mem_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.if_req || bus.d_req) begin
            win_data <= grant_data;
            if (grant_data) begin
              bus.mem_we    <= bus.d_we;
              bus.mem_addr  <= bus.d_addr[ADDR_W-1:2];
              bus.mem_wdata <= bus.d_wdata;
              if (bus.d_addr[1:0] != 2'b00) begin
                // Misaligned: report the error without touching memory.
                state     <= S_DONE;
                bus.d_ack <= 1'b1;
                bus.d_err <= 1'b1;
              end else begin
                state      <= S_ISSUE;
                bus.mem_en <= 1'b1;
              end
            end else begin
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= bus.if_addr[ADDR_W-1:2];
              bus.mem_wdata <= '0;
              state         <= S_ISSUE;
              bus.mem_en    <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          cnt   <= 3'(MEM_LAT - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == 3'd0) begin
            // mem_rdata is valid this cycle; the ack goes out in DONE.
            state <= S_DONE;
            if (win_data) begin
              bus.d_ack <= 1'b1;
              if (!bus.mem_we) begin
                bus.d_rdata <= bus.mem_rdata;
              end
            end else begin
              bus.if_ack   <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed plus randomized transactions against a transaction-level
// model (expected ack cycles, memory contents, grant order). A second instance with
// MEM_LAT=3 covers reset abort and back-to-back fetch streaming.
`timescale 1ns/1ps

module tb_mem_port_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MEM_LAT  = 1;
  localparam int MEM_LAT3 = 3;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst3 = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input bit ok, input logic [133:0] obs, input logic [133:0] exp_v);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc3 ();
  logic [1:0] dbg_state;
  logic [1:0] dbg_state3;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc),
    .dbg_state (dbg_state)
  );

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT3)) u_dut3 (
    .clk       (clk),
    .rst       (rst3),
    .bus       (ifc3),
    .dbg_state (dbg_state3)
  );

  // ---------------- memory models ----------------
  logic [31:0] mem_arr [0:63];
  int          rd_left = 0;
  logic [29:0] rd_addr = '0;
  always @(posedge clk) begin
    if (ifc.mem_en) begin
      if (ifc.mem_we) mem_arr[ifc.mem_addr[5:0]] = ifc.mem_wdata;
      else begin
        rd_left <= MEM_LAT;
        rd_addr <= ifc.mem_addr;
      end
    end else if (rd_left != 0) begin
      rd_left <= rd_left - 1;
    end
  end
  assign ifc.mem_rdata = (rd_left == 1) ? mem_arr[rd_addr[5:0]] : 32'hDEAD_BEEF;

  int          rd3_left = 0;
  logic [29:0] rd3_addr = '0;
  always @(posedge clk) begin
    if (ifc3.mem_en && !ifc3.mem_we) begin
      rd3_left <= MEM_LAT3;
      rd3_addr <= ifc3.mem_addr;
    end else if (rd3_left != 0) begin
      rd3_left <= rd3_left - 1;
    end
  end
  assign ifc3.mem_rdata = (rd3_left == 1) ? (32'h5A5A_0000 ^ {2'b00, rd3_addr}) : 32'hDEAD_BEEF;

  // ---------------- invariant monitors ----------------
  logic prev_en  = 1'b0;
  logic prev_en3 = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("dual_ack", (ifc.if_ack & ifc.d_ack) === 1'b0, ifc.if_ack & ifc.d_ack, 1'b0);
      chk("mem_en_b2b", (prev_en & ifc.mem_en) === 1'b0, prev_en & ifc.mem_en, 1'b0);
    end
    if (!rst3) begin
      chk("mem_en_b2b_lat3", (prev_en3 & ifc3.mem_en) === 1'b0, prev_en3 & ifc3.mem_en, 1'b0);
    end
    prev_en  = ifc.mem_en;
    prev_en3 = ifc3.mem_en;
  end

  // ---------------- reference model state / scoreboard ----------------
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata  = '0;
  bit          last_data    = 1'b0;
  logic [62:0] exp_q[$];      // {we, word address, wdata} per expected memory access

  // Run one group of requests starting in an idle cycle; requests are held until acked.
  task automatic run_txn(input bit f_en, input bit d_en, input bit we,
                         input logic [31:0] fa, input logic [31:0] da, input logic [31:0] wd);
    int a_f, a_d, n, ack, last_ack, n_f, n_d, got_f, got_d, cnt_f, cnt_d;
    bit first_d, is_d, mis, exp_err;
    logic [31:0] exp_en, exp_busy, got_en, got_busy;
    logic [29:0] w;
    logic [62:0] e;
    @(negedge clk);
    a_f = -1; a_d = -1; n = 0; last_ack = 0; n_f = 99; n_d = 99;
    got_f = -1; got_d = -1; cnt_f = 0; cnt_d = 0; exp_err = 1'b0;
    exp_en = '0; exp_busy = '0; got_en = '0; got_busy = '0;
    exp_q.delete();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    first_d = d_en && (!f_en || !last_data);
`else
    first_d = d_en;
`endif
    // Predict grant order, ack cycles, memory traffic and returned data.
    for (int s = 0; s < 2; s++) begin
      is_d = (s == 0) ? first_d : !first_d;
      if ((is_d && d_en) || (!is_d && f_en)) begin
        last_data = is_d;
        w   = is_d ? da[31:2] : fa[31:2];
        mis = is_d && (da[1:0] != 2'b00);
        ack = mis ? n + 1 : n + 2 + MEM_LAT;
        for (int c = n + 1; c <= ack; c++) exp_busy[c] = 1'b1;
        if (is_d) begin a_d = ack; n_d = n; exp_err = mis; end
        else begin a_f = ack; n_f = n; end
        if (!mis) begin
          exp_en[n+1] = 1'b1;
          exp_q.push_back({is_d && we, w, wd});
          if (!is_d) exp_if_rdata = ref_mem[w[5:0]];
          else if (we) ref_mem[w[5:0]] = wd;
          else exp_d_rdata = ref_mem[w[5:0]];
        end
        last_ack = ack;
        n = ack + 1;
      end
    end
    // Drive and observe.
    ifc.if_req = f_en; ifc.if_addr = fa;
    ifc.d_req = d_en; ifc.d_we = we; ifc.d_addr = da; ifc.d_wdata = wd;
    for (int c = 1; c <= last_ack; c++) begin
      @(posedge clk); @(negedge clk);
      got_busy[c] = ifc.busy;
      if (ifc.mem_en) begin
        got_en[c] = 1'b1;
        chk("mem_q_nonempty", (exp_q.size() != 0) === 1'b1, exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("mem_we", ifc.mem_we === e[62], ifc.mem_we, e[62]);
          chk("mem_addr", ifc.mem_addr === e[61:32], ifc.mem_addr, e[61:32]);
          if (e[62]) chk("mem_wdata", ifc.mem_wdata === e[31:0], ifc.mem_wdata, e[31:0]);
        end
      end
      if (ifc.if_ack) begin
        cnt_f++;
        if (got_f < 0) got_f = c;
        chk("if_rdata", ifc.if_rdata === exp_if_rdata, ifc.if_rdata, exp_if_rdata);
        ifc.if_req = 1'b0;
      end
      if (ifc.d_ack) begin
        cnt_d++;
        if (got_d < 0) got_d = c;
        chk("d_err", ifc.d_err === exp_err, ifc.d_err, exp_err);
        chk("d_rdata", ifc.d_rdata === exp_d_rdata, ifc.d_rdata, exp_d_rdata);
        ifc.d_req = 1'b0;
      end
      // Once latched, requester fields may wander without effect.
      if (c > n_f) ifc.if_addr = $urandom;
      if (c > n_d) begin
        ifc.d_addr = $urandom; ifc.d_wdata = $urandom; ifc.d_we = 1'($urandom);
      end
    end
    ifc.if_req = 1'b0;
    ifc.d_req  = 1'b0;
    chk("if_ack_cycle", got_f === a_f, got_f, a_f);
    chk("d_ack_cycle", got_d === a_d, got_d, a_d);
    chk("if_ack_count", cnt_f === (f_en ? 1 : 0), cnt_f, f_en ? 1 : 0);
    chk("d_ack_count", cnt_d === (d_en ? 1 : 0), cnt_d, d_en ? 1 : 0);
    chk("mem_en_cycles", got_en === exp_en, got_en, exp_en);
    chk("busy_cycles", got_busy === exp_busy, got_busy, exp_busy);
    chk("if_rdata_hold", ifc.if_rdata === exp_if_rdata, ifc.if_rdata, exp_if_rdata);
    chk("d_rdata_hold", ifc.d_rdata === exp_d_rdata, ifc.d_rdata, exp_d_rdata);
  endtask

  // ---------------- stimulus ----------------
  logic [133:0] ov;
  int k, got, en_cnt, prev, n_ack;

  initial begin
    ifc.if_req = 0; ifc.if_addr = 0; ifc.d_req = 0; ifc.d_we = 0; ifc.d_addr = 0; ifc.d_wdata = 0;
    ifc3.if_req = 0; ifc3.if_addr = 0; ifc3.d_req = 0; ifc3.d_we = 0; ifc3.d_addr = 0; ifc3.d_wdata = 0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      mem_arr[i] = ref_mem[i];
    end
    ref_mem[2] = 32'h2001_0005;
    mem_arr[2] = 32'h2001_0005;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    ov = {ifc.if_ack, ifc.d_ack, ifc.d_err, ifc.if_rdata, ifc.d_rdata, ifc.mem_en, ifc.mem_we,
          ifc.mem_addr, ifc.mem_wdata, ifc.busy, dbg_state};
    chk("reset_outputs", ov === 134'd0, ov, 134'd0);
    ov = {ifc3.if_ack, ifc3.d_ack, ifc3.d_err, ifc3.if_rdata, ifc3.d_rdata, ifc3.mem_en, ifc3.mem_we,
          ifc3.mem_addr, ifc3.mem_wdata, ifc3.busy, dbg_state3};
    chk("reset_outputs_lat3", ov === 134'd0, ov, 134'd0);
    rst = 1'b0;

    // Directed: fetch, store, load-back, tie, misaligned load and store.
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h0);
    run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0004, 32'd42);
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0004, 32'h0);
    run_txn(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0004, 32'h0);
    run_txn(1'b1, 1'b1, 1'b1, 32'h0000_0015, 32'h0000_0020, 32'h1234_5678);
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0006, 32'h0);
    run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0007, 32'h0000_0055);

    // Randomized mix.
    for (int i = 0; i < 30; i++) begin
      int kind;
      logic [31:0] fa, da, wd;
      bit we;
      kind = $urandom_range(0, 4);
      fa = {24'b0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      da = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
      wd = $urandom;
      we = 1'($urandom_range(0, 1));
      if (kind == 3 || (kind == 4 && $urandom_range(0, 3) == 0)) da[1:0] = 2'($urandom_range(1, 3));
      case (kind)
        0:       run_txn(1'b1, 1'b0, 1'b0, fa, da, wd);
        1:       run_txn(1'b0, 1'b1, 1'b0, fa, da, wd);
        2:       run_txn(1'b0, 1'b1, 1'b1, fa, da, wd);
        3:       run_txn(1'b0, 1'b1, we, fa, da, wd);
        default: run_txn(1'b1, 1'b1, we, fa, da, wd);
      endcase
    end

    // MEM_LAT=3: reset while waiting on memory aborts the fetch silently.
    @(negedge clk); rst3 = 1'b0;
    @(negedge clk);
    ifc3.if_req = 1'b1; ifc3.if_addr = 32'h0000_0044;
    k = 0;
    while (dbg_state3 != 2'd2 && k < 10) begin
      @(posedge clk); @(negedge clk); k++;
    end
    chk("reached_wait", dbg_state3 === 2'd2, dbg_state3, 2'd2);
    rst3 = 1'b1; ifc3.if_req = 1'b0;
    @(posedge clk); @(negedge clk);
    ov = {ifc3.if_ack, ifc3.d_ack, ifc3.d_err, ifc3.if_rdata, ifc3.d_rdata, ifc3.mem_en, ifc3.mem_we,
          ifc3.mem_addr, ifc3.mem_wdata, ifc3.busy, dbg_state3};
    chk("abort_outputs", ov === 134'd0, ov, 134'd0);
    rst3 = 1'b0;
    got = 0; en_cnt = 0;
    repeat (8) begin
      @(posedge clk); @(negedge clk);
      got += ifc3.if_ack;
      en_cnt += ifc3.mem_en;
    end
    chk("abort_no_ack", got === 0, got, 0);
    chk("abort_no_mem_en", en_cnt === 0, en_cnt, 0);

    // MEM_LAT=3: continuous fetch request streams one access every MEM_LAT+3 cycles.
    ifc3.if_req = 1'b1; ifc3.if_addr = 32'h0000_004B;
    prev = -1; en_cnt = 0; n_ack = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      if (ifc3.mem_en) begin
        if (prev >= 0) chk("stream_period", (c - prev) === (MEM_LAT3 + 3), c - prev, MEM_LAT3 + 3);
        prev = c;
        en_cnt++;
        chk("stream_addr", ifc3.mem_addr === 30'h12, ifc3.mem_addr, 30'h12);
      end
      if (ifc3.if_ack) begin
        n_ack++;
        chk("stream_rdata", ifc3.if_rdata === 32'h5A5A_0012, ifc3.if_rdata, 32'h5A5A_0012);
      end
    end
    ifc3.if_req = 1'b0;
    chk("stream_en_count", en_cnt === 7, en_cnt, 7);
    chk("stream_ack_count", n_ack === 6, n_ack, 6);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case the sequence above stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed %0d mismatches so far", n_bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, word-wide memory between two requesters of the single-cycle CPU:
  - instruction fetch (read-only);
  - data load/store path (lw/sw).
- Sequences each access through a small FSM with a fixed memory read latency.
- Returns data and a one-cycle acknowledge to the winning requester.
- `busy` is provided so the CPU stalls its PC and register write-back until the acknowledge.

Parameters:
- ADDR_W, 32, byte-address width of requester addresses.
- DATA_W, 32, data word width.
- MEM_LAT, 1, cycles from `mem_en` asserted to `mem_rdata` valid; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, level
- if_addr  in  ADDR_W  fetch byte address
- if_ack  out  1  one-cycle pulse, fetch transaction complete
- if_rdata  out  DATA_W  fetched instruction, valid with `if_ack`, held until the next fetch ack
- d_req  in  1  data request, level
- d_we  in  1  1 = store (sw), 0 = load (lw)
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle pulse, data transaction complete
- d_err  out  1  valid with `d_ack`; 1 = misaligned address, no access performed
- d_rdata  out  DATA_W  load data, valid with `d_ack`, held until the next data ack
- mem_en  out  1  memory access strobe, exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by `mem_en`
- mem_addr  out  ADDR_W-2  word address = latched addr[ADDR_W-1:2]
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after `mem_en`
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset:
  - all outputs 0;
  - FSM to IDLE, latency counter 0;
  - arbitration pointer = "fetch last granted".
  - Reset mid-transaction aborts it; no ack is issued for it.
- FSM states and transitions:
  - IDLE:
    - samples `if_req` / `d_req`.
    - If any request is present: select a winner; latch its addr, we (fetch forces 0) and wdata; go to ISSUE.
    - If the winner is data with d_addr[1:0] != 0: go to DONE with d_err=1 and no memory access.
  - ISSUE: `mem_en`=1, `mem_we`/`mem_addr`/`mem_wdata` from latches; counter loads MEM_LAT-1; go to WAIT.
  - WAIT:
    - counter decrements.
    - When counter == 0, `mem_rdata` is valid: capture into the winner's rdata register (loads and fetches only; a store leaves `d_rdata` unchanged); go to DONE.
  - DONE: pulse the winner's ack (and `d_err` if applicable); go to IDLE.
- Latency:
  - request sampled in IDLE at cycle N → `mem_en` at N+1 → ack at N+2+MEM_LAT.
  - Stores use the same latency.
  - Misaligned data: ack at N+1.
- Handshake rules:
  - req is level-sensitive and sampled only in IDLE.
  - A requester holding req high in the cycle after its ack starts a new transaction.
  - Address and data changes after latching are ignored.
  - A req dropped before its ack does not cancel the transaction; the ack is still pulsed.
- Arbitration (default, no macro): fixed priority, data > fetch. When both request simultaneously, data wins and fetch waits for the next IDLE.
- `if_ack` and `d_ack` are never high in the same cycle. `mem_en` is never high in two consecutive cycles.
- Fetch ignores if_addr[1:0].

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - on simultaneous requests, grant the requester not granted last;
  - pointer updates on every grant;
  - pointer resets to "fetch last granted", so data wins the first tie.
- Undefined: fixed data > fetch priority as above; the pointer logic is absent.

Test Plan:
- MEM_LAT=1. if_req=1, if_addr=0x0000_0008 at cycle 0:
  - `mem_en`=1, mem_addr=0x2 at cycle 1;
  - mem_rdata=0x2001_0005 at cycle 2;
  - if_ack=1, if_rdata=0x2001_0005 at cycle 3; busy high during cycles 1-3.
- d_req=1, d_we=1, d_addr=0x4, d_wdata=42 (sw):
  - `mem_en`/`mem_we`=1, mem_addr=0x1, mem_wdata=42;
  - d_ack after 3 cycles, d_err=0.
- Then lw from d_addr=0x4 against a 1-entry memory model returns d_rdata=42.
- if_req and d_req both high at the same cycle:
  - default build: d_ack first, if_ack exactly 4 cycles later;
  - with MEM_ARB_ROUND_ROBIN_EN and d_req, if_req held high: grants alternate data, fetch, data.
- d_addr=0x6: d_ack=1 with d_err=1 one cycle later; `mem_en` never asserted.
- rst asserted in the WAIT state (MEM_LAT=3): the next cycle has all outputs 0 and FSM in IDLE; no ack for the aborted request.
- if_req held high continuously: `mem_en` pulses every MEM_LAT+3 cycles (IDLE, ISSUE, WAIT×MEM_LAT, DONE), never on consecutive cycles.
